qpsk_tx_symbol_scheduler: RTL and testbench

//  Sequences the combinational QPSK modulator for the transmit path: accepts one 7-bit

---
 rtl/qpsk_tx_symbol_scheduler.sv | 174 +++++++++++++++++
 tb/tb_qpsk_tx_symbol_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_tx_symbol_scheduler.sv
// qpsk_tx_symbol_scheduler
//   Sequences a combinational QPSK modulator on the transmit path. It accepts one codeword
//   per valid/ready handshake and drives it onto the modulator input. One cycle later it
//   captures the modulator's four parallel symbol pairs into shadow registers. It then
//   emits those pairs serially, holding each one for SYM_PERIOD clocks.
//
// Ports
//   i_clk                 system clock, rising edge
//   i_reset               synchronous, active-high reset
//   i_cw_in / i_cw_valid  codeword from the encoder and its valid
//   o_cw_ready            high in IDLE (decoded from state)
//   o_mod_in              registered codeword driven to the modulator
//   i_mod_real_k/imag_k   modulator symbol k (k=1 sent first)
//   o_sym_real/imag       current serial symbol (0 outside SEND)
//   o_sym_strobe          1-cycle pulse on the first clock of each symbol
//   o_sym_idx             index of the current symbol, 0..3
//   o_sym_last            high for the whole period of symbol 3
//   o_busy                high in LOAD or SEND (decoded from state)
//   o_frames_sent         completed codewords, wraps 255 -> 0
module qpsk_tx_symbol_scheduler #(
    parameter int unsigned SYM_W      = 16,
    parameter int unsigned CW_W       = 7,
    parameter int unsigned SYM_PERIOD = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [CW_W-1:0]  i_cw_in,
    input  logic             i_cw_valid,
    output logic             o_cw_ready,
    output logic [CW_W-1:0]  o_mod_in,
    input  logic [SYM_W-1:0] i_mod_real_1,
    input  logic [SYM_W-1:0] i_mod_real_2,
    input  logic [SYM_W-1:0] i_mod_real_3,
    input  logic [SYM_W-1:0] i_mod_real_4,
    input  logic [SYM_W-1:0] i_mod_imag_1,
    input  logic [SYM_W-1:0] i_mod_imag_2,
    input  logic [SYM_W-1:0] i_mod_imag_3,
    input  logic [SYM_W-1:0] i_mod_imag_4,
    output logic [SYM_W-1:0] o_sym_real,
    output logic [SYM_W-1:0] o_sym_imag,
    output logic             o_sym_strobe,
    output logic [1:0]       o_sym_idx,
    output logic             o_sym_last,
    output logic             o_busy,
    output logic [7:0]       o_frames_sent
);

    localparam logic [7:0] LastCnt = 8'(SYM_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [CW_W-1:0]  r_mod_in;
    logic [SYM_W-1:0] r_sh_real [4];
    logic [SYM_W-1:0] r_sh_imag [4];
    logic [7:0]       r_per_cnt;
    logic [1:0]       r_sym_idx;
    logic [SYM_W-1:0] r_sym_real;
    logic [SYM_W-1:0] r_sym_imag;
    logic             r_sym_strobe;
    logic             r_sym_last;
    logic [7:0]       r_frames;

    logic       w_accept;
    logic       w_sym_end;
    logic       w_frame_end;
    logic [1:0] w_idx_nxt;

    assign w_accept    = (r_state == StIdle) && i_cw_valid;
    assign w_sym_end   = (r_state == StSend) && (r_per_cnt == LastCnt);
    assign w_frame_end = w_sym_end && (r_sym_idx == 2'd3);
    assign w_idx_nxt   = r_sym_idx + 2'd1;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StLoad;
            StLoad:  w_state_d = StSend;
            StSend:  if (w_frame_end) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Datapath. The serial outputs are registered, so each edge loads the value for the
    // cycle that follows it. The LOAD edge therefore presents symbol 0 straight from the
    // modulator while it is also being captured into the shadow registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mod_in     <= '0;
            r_per_cnt    <= '0;
            r_sym_idx    <= '0;
            r_sym_real   <= '0;
            r_sym_imag   <= '0;
            r_sym_strobe <= 1'b0;
            r_sym_last   <= 1'b0;
            r_frames     <= '0;
            for (int k = 0; k < 4; k++) begin
                r_sh_real[k] <= '0;
                r_sh_imag[k] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) r_mod_in <= i_cw_in;
                    r_per_cnt <= '0;
                end
                StLoad: begin
                    r_sh_real[0] <= i_mod_real_1;
                    r_sh_real[1] <= i_mod_real_2;
                    r_sh_real[2] <= i_mod_real_3;
                    r_sh_real[3] <= i_mod_real_4;
                    r_sh_imag[0] <= i_mod_imag_1;
                    r_sh_imag[1] <= i_mod_imag_2;
                    r_sh_imag[2] <= i_mod_imag_3;
                    r_sh_imag[3] <= i_mod_imag_4;
                    r_per_cnt    <= '0;
                    r_sym_idx    <= 2'd0;
                    r_sym_real   <= i_mod_real_1;
                    r_sym_imag   <= i_mod_imag_1;
                    r_sym_strobe <= 1'b1;
                    r_sym_last   <= 1'b0;
                end
                StSend: begin
                    if (w_sym_end) begin
                        r_per_cnt <= '0;
                        if (r_sym_idx == 2'd3) begin
                            // Frame complete: serial outputs return to idle zeros
                            r_frames     <= r_frames + 8'd1;
                            r_sym_idx    <= 2'd0;
                            r_sym_real   <= '0;
                            r_sym_imag   <= '0;
                            r_sym_strobe <= 1'b0;
                            r_sym_last   <= 1'b0;
                        end else begin
                            r_sym_idx    <= w_idx_nxt;
                            r_sym_real   <= r_sh_real[w_idx_nxt];
                            r_sym_imag   <= r_sh_imag[w_idx_nxt];
                            r_sym_strobe <= 1'b1;
                            r_sym_last   <= (w_idx_nxt == 2'd3);
                        end
                    end else begin
                        r_per_cnt    <= r_per_cnt + 8'd1;
                        r_sym_strobe <= 1'b0;
                    end
                end
                default: begin
                    r_per_cnt <= '0;
                end
            endcase
        end
    end

    assign o_cw_ready    = (r_state == StIdle);
    assign o_busy        = (r_state != StIdle);
    assign o_mod_in      = r_mod_in;
    assign o_sym_real    = r_sym_real;
    assign o_sym_imag    = r_sym_imag;
    assign o_sym_strobe  = r_sym_strobe;
    assign o_sym_idx     = r_sym_idx;
    assign o_sym_last    = r_sym_last;
    assign o_frames_sent = r_frames;

endmodule

// File: tb/tb_qpsk_tx_symbol_scheduler.sv
module tb_qpsk_tx_symbol_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [6:0]  cw_in;
    logic        valid_a;
    logic        valid_b;
    logic [15:0] mr [4];
    logic [15:0] mi [4];

    logic        a_ready, a_strobe, a_last, a_busy;
    logic [6:0]  a_mod_in;
    logic [15:0] a_real, a_imag;
    logic [1:0]  a_idx;
    logic [7:0]  a_frames;
    logic        b_ready, b_strobe, b_last, b_busy;
    logic [6:0]  b_mod_in;
    logic [15:0] b_real, b_imag;
    logic [1:0]  b_idx;
    logic [7:0]  b_frames;

    qpsk_tx_symbol_scheduler #(.SYM_W(16), .CW_W(7), .SYM_PERIOD(4)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_cw_in(cw_in), .i_cw_valid(valid_a),
        .o_cw_ready(a_ready), .o_mod_in(a_mod_in),
        .i_mod_real_1(mr[0]), .i_mod_real_2(mr[1]), .i_mod_real_3(mr[2]), .i_mod_real_4(mr[3]),
        .i_mod_imag_1(mi[0]), .i_mod_imag_2(mi[1]), .i_mod_imag_3(mi[2]), .i_mod_imag_4(mi[3]),
        .o_sym_real(a_real), .o_sym_imag(a_imag), .o_sym_strobe(a_strobe), .o_sym_idx(a_idx),
        .o_sym_last(a_last), .o_busy(a_busy), .o_frames_sent(a_frames)
    );

    qpsk_tx_symbol_scheduler #(.SYM_W(16), .CW_W(7), .SYM_PERIOD(1)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_cw_in(cw_in), .i_cw_valid(valid_b),
        .o_cw_ready(b_ready), .o_mod_in(b_mod_in),
        .i_mod_real_1(mr[0]), .i_mod_real_2(mr[1]), .i_mod_real_3(mr[2]), .i_mod_real_4(mr[3]),
        .i_mod_imag_1(mi[0]), .i_mod_imag_2(mi[1]), .i_mod_imag_3(mi[2]), .i_mod_imag_4(mi[3]),
        .o_sym_real(b_real), .o_sym_imag(b_imag), .o_sym_strobe(b_strobe), .o_sym_idx(b_idx),
        .o_sym_last(b_last), .o_busy(b_busy), .o_frames_sent(b_frames)
    );

    // Selected DUT view: 0 -> SYM_PERIOD=4 instance, 1 -> SYM_PERIOD=1 instance
    int          sel = 0;
    logic [37:0] obs_t;
    logic [6:0]  o_mod_in;
    logic [7:0]  o_frames;
    logic        o_ready;
    assign obs_t    = (sel == 1) ? {b_busy, b_ready, b_strobe, b_idx, b_last, b_real, b_imag}
                                 : {a_busy, a_ready, a_strobe, a_idx, a_last, a_real, a_imag};
    assign o_mod_in = (sel == 1) ? b_mod_in : a_mod_in;
    assign o_frames = (sel == 1) ? b_frames : a_frames;
    assign o_ready  = (sel == 1) ? b_ready : a_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_frames [2];

    localparam logic [37:0] IdleTuple = {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'd0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_mod();
        for (int i = 0; i < 4; i++) begin
            mr[i] = {4'h0, 4'(i + 1), 4'h0, 4'(i + 1)};
            mi[i] = {4{4'(i + 1)}};
        end
    endtask

    task automatic set_random_mod();
        for (int i = 0; i < 4; i++) begin
            mr[i] = 16'($urandom);
            mi[i] = 16'($urandom);
        end
    endtask

    // Reference model: relative to handshake cycle T, cycle k=1 is LOAD, cycles
    // 2..1+4p are SEND with symbol s=(k-2)/p, and cycle 2+4p is IDLE again.
    task automatic run_frame(input int p, input logic [6:0] cw, input bit hold,
                             input logic [6:0] next_cw, input bit perturb, input int abort_k);
        logic [15:0] er [4];
        logic [15:0] ei [4];
        logic [37:0] e;
        int          s;
        for (int i = 0; i < 4; i++) begin
            er[i] = mr[i];
            ei[i] = mi[i];
        end
        cw_in = cw;
        if (sel == 1) valid_b = 1'b1; else valid_a = 1'b1;
        chk("ready_at_handshake", 64'(o_ready), 64'd1);
        for (int k = 1; k <= 2 + 4 * p; k++) begin
            step();
            if (k == 1) begin
                if (hold) begin
                    cw_in = next_cw;
                end else begin
                    valid_a = 1'b0;
                    valid_b = 1'b0;
                end
            end
            if (k == 1) begin
                e = {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0};
            end else if (k <= 1 + 4 * p) begin
                s = (k - 2) / p;
                e = {1'b1, 1'b0, ((k - 2) % p == 0), 2'(s), (s == 3), er[s], ei[s]};
            end else begin
                exp_frames[sel] = (exp_frames[sel] + 1) % 256;
                e = IdleTuple;
            end
            chk($sformatf("outputs p%0d cw%h k%0d", p, cw, k), 64'(obs_t), 64'(e));
            if (k == 1 || k == 2 + 4 * p)
                chk($sformatf("mod_in k%0d", k), 64'(o_mod_in), 64'(cw));
            if (k == 2 + 4 * p)
                chk("frames_sent", 64'(o_frames), 64'(exp_frames[sel]));
            if (perturb && k == 2) begin
                mr[0] = 16'hFFFF;
                mi[3] = 16'($urandom);
                mr[2] = 16'($urandom);
            end
            if (k == abort_k) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                exp_frames[0] = 0;
                exp_frames[1] = 0;
                chk("abort_outputs", 64'(obs_t), 64'(IdleTuple));
                chk("abort_mod_in", 64'(o_mod_in), 64'd0);
                chk("abort_frames", 64'(o_frames), 64'd0);
                return;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        valid_a = 1'b1;
        valid_b = 1'b1;
        cw_in   = 7'h55;
        set_default_mod();
        exp_frames[0] = 0;
        exp_frames[1] = 0;

        // Reset held two cycles with a simultaneous valid: reset wins
        for (int c = 0; c < 2; c++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                sel = d;
                #0;
                chk($sformatf("reset_outputs dut%0d c%0d", d, c), 64'(obs_t), 64'(IdleTuple));
                chk($sformatf("reset_mod_in dut%0d c%0d", d, c), 64'(o_mod_in), 64'd0);
                chk($sformatf("reset_frames dut%0d c%0d", d, c), 64'(o_frames), 64'd0);
            end
        end
        reset   = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        sel     = 0;
        step();

        // Single codeword
        run_frame(4, 7'b1100110, 1'b0, 7'd0, 1'b0, 0);
        step();
        // Back-to-back with valid held
        run_frame(4, 7'b1010011, 1'b1, 7'b0110001, 1'b0, 0);
        run_frame(4, 7'b0110001, 1'b0, 7'd0, 1'b0, 0);
        step();
        // Modulator inputs disturbed during SEND
        run_frame(4, 7'b0101010, 1'b0, 7'd0, 1'b1, 0);
        set_default_mod();
        step();
        // Randomized codewords and symbol values
        for (int f = 0; f < 10; f++) begin
            set_random_mod();
            run_frame(4, 7'($urandom), 1'b0, 7'd0, 1'b0, 0);
            if ($urandom_range(0, 1) == 1) step();
        end
        set_default_mod();
        step();
        // Reset in the middle of symbol 1, then a clean frame
        run_frame(4, 7'b0111000, 1'b0, 7'd0, 1'b0, 8);
        step();
        run_frame(4, 7'b0001110, 1'b0, 7'd0, 1'b0, 0);

        // SYM_PERIOD=1, 256 back-to-back-ish frames: counter wraps
        sel = 1;
        #0;
        step();
        for (int f = 0; f < 256; f++) begin
            set_random_mod();
            run_frame(1, 7'($urandom), 1'b0, 7'd0, 1'b0, 0);
        end
        chk("frames_wrapped", 64'(o_frames), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
